// File: rtl/spi_ctrl_pkg.sv
// Shared definitions for the SPI master controller: register offsets, bit positions,
// shift-engine states and reset values.
package spi_ctrl_pkg;

  localparam logic [2:0] REG_SPCR = 3'd0;
  localparam logic [2:0] REG_SPSR = 3'd1;
  localparam logic [2:0] REG_SPDR = 3'd2;
  localparam logic [2:0] REG_SPER = 3'd3;
  localparam logic [2:0] REG_SSR  = 3'd4;

  localparam int unsigned SPCR_SPIE = 7;
  localparam int unsigned SPCR_SPE  = 6;
  localparam int unsigned SPCR_CPOL = 3;
  localparam int unsigned SPCR_CPHA = 2;

  localparam int unsigned SPSR_SPIF = 7;
  localparam int unsigned SPSR_WCOL = 6;
  localparam int unsigned SPSR_ROVR = 5;

  localparam logic [7:0] SPCR_RESET = 8'h00;
  localparam logic [7:0] SPSR_RESET = 8'h05;

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} spi_state_e;

  // Terminal count of the divider: SCLK half-period is 2^(spr+1) Clk cycles.
  function automatic logic [3:0] half_m1(input logic [1:0] spr);
    case (spr)
      2'd0:    half_m1 = 4'd1;
      2'd1:    half_m1 = 4'd3;
      2'd2:    half_m1 = 4'd7;
      default: half_m1 = 4'd15;
    endcase
  endfunction

endpackage

// File: rtl/spi_fifo.sv
// Synchronous 8-bit FIFO with flush; push when full and pop when empty are ignored.
module spi_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       flush_i,
  input  logic       push_i,
  input  logic       pop_i,
  input  logic [7:0] wdata_i,
  output logic [7:0] rdata_o,
  output logic       full_o,
  output logic       empty_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   cnt_q;
  logic          do_push, do_pop;

  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign rdata_o = mem_q[rptr_q];

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + AW'(1);
      if (do_pop)  rptr_q <= rptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/spi_master_ctrl.sv
// 68k-facing SPI master: five byte registers, TX/RX FIFOs, SCLK divider, mode 0-3 engine.
// Optional LSB-first transfers are enabled by defining SPI_LSB_FIRST_EN.
module spi_master_ctrl
  import spi_ctrl_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned SS_WIDTH   = 8
) (
  input  logic                Clk,
  input  logic                Reset_H,
  input  logic                SPI_Enable_H,
  input  logic [3:0]          Address,
  input  logic                WE_L,
  input  logic [7:0]          DataIn,
  output logic [7:0]          DataOut,
  output logic                IRQ_L,
  output logic                SCLK,
  output logic                MOSI,
  input  logic                MISO,
  output logic [SS_WIDTH-1:0] SS_L
);

  logic          en_q, acc, wr, rd;
  logic [2:0]    sel;
  logic          unused_addr0;
  logic          spie_q, spe_q, cpol_q, cpha_q;
  logic [1:0]    spr_q;
  logic [SS_WIDTH-1:0] ssr_q;
  logic          spif_q, wcol_q, rovr_q, spif_d, wcol_d, rovr_d;
  logic [7:0]    dataout_q, rdata;
  logic          lsbfe;
  logic          wr_spcr, wr_spsr, wr_spdr, abort;
  logic          tx_full, tx_empty, rx_full, rx_empty;
  logic [7:0]    tx_head, rx_head;
  logic          tx_pop, rx_push, set_spif, set_rovr;

  spi_state_e    state_q, state_d;
  logic          sclk_q, sclk_d, mosi_q, mosi_d;
  logic [3:0]    div_q, div_d;
  logic [4:0]    edge_q, edge_d, edge_n;
  logic [7:0]    tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d;
  logic          cpha_l_q, cpha_l_d, lsb_l_q, lsb_l_d;
  logic [1:0]    spr_l_q, spr_l_d;
  logic          tick, shift_edge, sample_edge;

  // One register action per bus cycle: only the rising edge of the chip enable counts.
  assign acc          = SPI_Enable_H & ~en_q;
  assign wr           = acc & ~WE_L;
  assign rd           = acc & WE_L;
  assign sel          = Address[3:1];
  assign unused_addr0 = Address[0];
  assign wr_spcr      = wr && (sel == REG_SPCR);
  assign wr_spsr      = wr && (sel == REG_SPSR);
  assign wr_spdr      = wr && (sel == REG_SPDR);
  assign abort        = wr_spcr && !DataIn[SPCR_SPE] && (state_q != IDLE);

  spi_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk_i   (Clk),
    .rst_i   (Reset_H),
    .flush_i (abort),
    .push_i  (wr_spdr),
    .pop_i   (tx_pop),
    .wdata_i (DataIn),
    .rdata_o (tx_head),
    .full_o  (tx_full),
    .empty_o (tx_empty)
  );

  spi_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk_i   (Clk),
    .rst_i   (Reset_H),
    .flush_i (abort),
    .push_i  (rx_push),
    .pop_i   (rd && (sel == REG_SPDR)),
    .wdata_i (rx_sh_q),
    .rdata_o (rx_head),
    .full_o  (rx_full),
    .empty_o (rx_empty)
  );

`ifdef SPI_LSB_FIRST_EN
  logic lsbfe_q;
  always_ff @(posedge Clk) begin
    if (Reset_H) lsbfe_q <= 1'b0;
    else if (wr && (sel == REG_SPER)) lsbfe_q <= DataIn[0];
  end
  assign lsbfe = lsbfe_q;
`else
  assign lsbfe = 1'b0;
`endif

  always_comb begin
    rdata = 8'h00;
    case (sel)
      REG_SPCR: rdata = {spie_q, spe_q, 2'b00, cpol_q, cpha_q, spr_q};
      REG_SPSR: rdata = {spif_q, wcol_q, rovr_q, 1'b0, tx_full, tx_empty, rx_full, rx_empty};
      REG_SPDR: rdata = rx_empty ? 8'h00 : rx_head;
      REG_SPER: rdata = {7'b0, lsbfe};
      REG_SSR:  rdata = 8'(ssr_q);
      default:  rdata = 8'h00;
    endcase
  end

  // Hardware sets beat software W1C clears in the same cycle.
  always_comb begin
    spif_d = (spif_q & ~(wr_spsr & DataIn[SPSR_SPIF])) | set_spif;
    wcol_d = (wcol_q & ~(wr_spsr & DataIn[SPSR_WCOL])) | (wr_spdr & tx_full);
    rovr_d = (rovr_q & ~(wr_spsr & DataIn[SPSR_ROVR])) | set_rovr;
  end

  always_ff @(posedge Clk) begin
    if (Reset_H) begin
      en_q      <= 1'b0;
      {spie_q, spe_q, cpol_q, cpha_q} <= {SPCR_RESET[7:6], SPCR_RESET[3:2]};
      spr_q     <= SPCR_RESET[1:0];
      ssr_q     <= '0;
      spif_q    <= SPSR_RESET[SPSR_SPIF];
      wcol_q    <= SPSR_RESET[SPSR_WCOL];
      rovr_q    <= SPSR_RESET[SPSR_ROVR];
      dataout_q <= 8'h00;
    end else begin
      en_q   <= SPI_Enable_H;
      spif_q <= spif_d;
      wcol_q <= wcol_d;
      rovr_q <= rovr_d;
      if (wr_spcr) begin
        spie_q <= DataIn[SPCR_SPIE];
        spe_q  <= DataIn[SPCR_SPE];
        cpol_q <= DataIn[SPCR_CPOL];
        cpha_q <= DataIn[SPCR_CPHA];
        spr_q  <= DataIn[1:0];
      end
      if (wr && (sel == REG_SSR)) ssr_q <= SS_WIDTH'(DataIn);
      if (rd) dataout_q <= rdata;
    end
  end

  assign DataOut = dataout_q;
  assign IRQ_L   = ~(spie_q & spif_q);
  assign SS_L    = ~ssr_q;
  assign SCLK    = sclk_q;
  assign MOSI    = mosi_q;

  assign tick        = (div_q == half_m1(spr_l_q));
  assign edge_n      = edge_q + 5'd1;
  assign shift_edge  = cpha_l_q ? edge_n[0] : (!edge_n[0] && (edge_n != 5'd16));
  assign sample_edge = cpha_l_q ? !edge_n[0] : edge_n[0];

  always_comb begin
    state_d  = state_q;
    sclk_d   = sclk_q;
    mosi_d   = mosi_q;
    div_d    = div_q;
    edge_d   = edge_q;
    tx_sh_d  = tx_sh_q;
    rx_sh_d  = rx_sh_q;
    cpha_l_d = cpha_l_q;
    spr_l_d  = spr_l_q;
    lsb_l_d  = lsb_l_q;
    tx_pop   = 1'b0;
    rx_push  = 1'b0;
    set_spif = 1'b0;
    set_rovr = 1'b0;
    unique case (state_q)
      IDLE: begin
        sclk_d = cpol_q;
        mosi_d = 1'b1;
        if (spe_q && !tx_empty) state_d = LOAD;
      end
      LOAD: begin
        tx_pop   = 1'b1;
        cpha_l_d = cpha_q;
        spr_l_d  = spr_q;
        lsb_l_d  = lsbfe;
        sclk_d   = cpol_q;
        div_d    = '0;
        edge_d   = '0;
        rx_sh_d  = 8'h00;
        tx_sh_d  = tx_head;
        // CPHA=0 puts the first bit on MOSI before the first SCLK edge.
        if (!cpha_q) begin
          mosi_d  = lsbfe ? tx_head[0] : tx_head[7];
          tx_sh_d = lsbfe ? (tx_head >> 1) : (tx_head << 1);
        end
        state_d = SHIFT;
      end
      SHIFT: begin
        div_d = div_q + 4'd1;
        if (tick) begin
          div_d  = '0;
          sclk_d = ~sclk_q;
          edge_d = edge_n;
          if (shift_edge) begin
            mosi_d  = lsb_l_q ? tx_sh_q[0] : tx_sh_q[7];
            tx_sh_d = lsb_l_q ? (tx_sh_q >> 1) : (tx_sh_q << 1);
          end
          if (sample_edge) begin
            rx_sh_d = lsb_l_q ? {MISO, rx_sh_q[7:1]} : {rx_sh_q[6:0], MISO};
          end
          if (edge_n == 5'd16) state_d = DONE;
        end
      end
      DONE: begin
        rx_push  = 1'b1;
        set_spif = 1'b1;
        set_rovr = rx_full;
        state_d  = (spe_q && !tx_empty) ? LOAD : IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (abort) begin
      state_d = IDLE;
      sclk_d  = DataIn[SPCR_CPOL];
      mosi_d  = 1'b1;
      tx_pop  = 1'b0;
      rx_push = 1'b0;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset_H) begin
      state_q  <= IDLE;
      sclk_q   <= 1'b0;
      mosi_q   <= 1'b1;
      div_q    <= '0;
      edge_q   <= '0;
      tx_sh_q  <= 8'h00;
      rx_sh_q  <= 8'h00;
      cpha_l_q <= 1'b0;
      spr_l_q  <= 2'd0;
      lsb_l_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      sclk_q   <= sclk_d;
      mosi_q   <= mosi_d;
      div_q    <= div_d;
      edge_q   <= edge_d;
      tx_sh_q  <= tx_sh_d;
      rx_sh_q  <= rx_sh_d;
      cpha_l_q <= cpha_l_d;
      spr_l_q  <= spr_l_d;
      lsb_l_q  <= lsb_l_d;
    end
  end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Directed bench for spi_master_ctrl: register vector table plus transfer sequences
// with MISO looped back to MOSI.
module tb_spi_master_ctrl;

  logic       Clk = 1'b0;
  logic       Reset_H = 1'b1;
  logic       SPI_Enable_H = 1'b0;
  logic [3:0] Address = 4'h0;
  logic       WE_L = 1'b1;
  logic [7:0] DataIn = 8'h00;
  logic [7:0] DataOut;
  logic       IRQ_L, SCLK, MOSI, MISO;
  logic [7:0] SS_L;

  int passes = 0;
  int total  = 0;

  assign MISO = MOSI;

  always #5 Clk = ~Clk;

  spi_master_ctrl #(.FIFO_DEPTH(4), .SS_WIDTH(8)) dut (
    .Clk          (Clk),
    .Reset_H      (Reset_H),
    .SPI_Enable_H (SPI_Enable_H),
    .Address      (Address),
    .WE_L         (WE_L),
    .DataIn       (DataIn),
    .DataOut      (DataOut),
    .IRQ_L        (IRQ_L),
    .SCLK         (SCLK),
    .MOSI         (MOSI),
    .MISO         (MISO),
    .SS_L         (SS_L)
  );

  // SCLK monitor: counts toggles, rising edges, high cycles; captures MOSI on rises.
  logic mon_clr = 1'b0;
  logic prev_sclk = 1'b0;
  int   toggles = 0, rises = 0, highs = 0;
  logic [7:0] cap = 8'h00;

  always @(negedge Clk) begin
    if (mon_clr) begin
      toggles <= 0;
      rises   <= 0;
      highs   <= 0;
      cap     <= 8'h00;
    end else begin
      if (SCLK !== prev_sclk) toggles <= toggles + 1;
      if (SCLK && !prev_sclk) begin
        rises <= rises + 1;
        cap   <= {cap[6:0], MOSI};
      end
      if (SCLK) highs <= highs + 1;
    end
    prev_sclk <= SCLK;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic bus_cycle(input logic [2:0] idx, input logic we, input logic [7:0] d,
                           input int hold);
    @(posedge Clk);
    #1;
    SPI_Enable_H = 1'b1;
    Address      = {idx, 1'b0};
    WE_L         = ~we;
    DataIn       = d;
    repeat (hold) @(posedge Clk);
    #1;
    SPI_Enable_H = 1'b0;
    WE_L         = 1'b1;
  endtask

  task automatic bus_write(input logic [2:0] idx, input logic [7:0] d);
    bus_cycle(idx, 1'b1, d, 1);
  endtask

  task automatic bus_read(input logic [2:0] idx, output logic [7:0] d);
    bus_cycle(idx, 1'b0, 8'h00, 1);
    d = DataOut;
  endtask

  task automatic read_check(input string name, input logic [2:0] idx, input logic [7:0] exp);
    logic [7:0] d;
    bus_read(idx, d);
    check(name, d, exp);
  endtask

  task automatic clear_monitor();
    repeat (2) @(posedge Clk);
    @(posedge Clk);
    #1 mon_clr = 1'b1;
    @(negedge Clk);
    #1 mon_clr = 1'b0;
  endtask

  task automatic wait_irq(input string name, input int max_cycles);
    int n = 0;
    while (IRQ_L !== 1'b0 && n < max_cycles) begin
      @(posedge Clk);
      n++;
    end
    #1 check(name, IRQ_L, 1'b0);
  endtask

  typedef struct {
    logic [2:0] idx;
    logic       wr;
    logic [7:0] data;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[$];
  logic [7:0] sper_exp;

  initial begin
`ifdef SPI_LSB_FIRST_EN
    sper_exp = 8'h01;
`else
    sper_exp = 8'h00;
`endif
    vecs.push_back('{3'd1, 1'b0, 8'h00, 8'h05});    // SPSR reset
    vecs.push_back('{3'd0, 1'b0, 8'h00, 8'h00});    // SPCR reset
    vecs.push_back('{3'd3, 1'b0, 8'h00, 8'h00});    // SPER reset
    vecs.push_back('{3'd4, 1'b0, 8'h00, 8'h00});    // SSR reset
    vecs.push_back('{3'd2, 1'b0, 8'h00, 8'h00});    // SPDR read, RX empty
    vecs.push_back('{3'd0, 1'b1, 8'hFF, 8'h00});
    vecs.push_back('{3'd0, 1'b0, 8'h00, 8'hCF});    // reserved SPCR bits read 0
    vecs.push_back('{3'd0, 1'b1, 8'h00, 8'h00});
    vecs.push_back('{3'd5, 1'b1, 8'hFF, 8'h00});
    vecs.push_back('{3'd5, 1'b0, 8'h00, 8'h00});
    vecs.push_back('{3'd7, 1'b0, 8'h00, 8'h00});
    vecs.push_back('{3'd3, 1'b1, 8'hFF, 8'h00});
    vecs.push_back('{3'd3, 1'b0, 8'h00, sper_exp});
    vecs.push_back('{3'd3, 1'b1, 8'h00, 8'h00});
    vecs.push_back('{3'd4, 1'b1, 8'h5A, 8'h00});
    vecs.push_back('{3'd4, 1'b0, 8'h00, 8'h5A});
    vecs.push_back('{3'd4, 1'b1, 8'h01, 8'h00});

    repeat (3) @(posedge Clk);
    #1 Reset_H = 1'b0;
    @(negedge Clk);
    check("rst_ss_l", SS_L, 8'hFF);
    check("rst_irq_l", IRQ_L, 1'b1);
    check("rst_sclk", SCLK, 1'b0);
    check("rst_mosi", MOSI, 1'b1);
    check("rst_dataout", DataOut, 8'h00);

    foreach (vecs[i]) begin
      if (vecs[i].wr) bus_write(vecs[i].idx, vecs[i].data);
      else read_check($sformatf("vec%0d", i), vecs[i].idx, vecs[i].exp);
    end
    check("ss_l_ssr01", SS_L, 8'hFE);

    // Mode 0, /4, loopback of 0xA5.
    bus_write(3'd0, 8'hC0);
    clear_monitor();
    bus_write(3'd2, 8'hA5);
    wait_irq("a5_irq", 200);
    check("a5_rises", rises, 8);
    check("a5_high_cycles", highs, 16);
    check("a5_mosi_capture", cap, 8'hA5);
    check("a5_sclk_idle", SCLK, 1'b0);
    read_check("a5_spdr", 3'd2, 8'hA5);
    read_check("a5_spsr", 3'd1, 8'h85);
    bus_write(3'd1, 8'h80);
    #1 check("spif_w1c_irq", IRQ_L, 1'b1);

    // Long enable: one push only; then fill TX and overflow it.
    bus_write(3'd0, 8'h00);
    bus_cycle(3'd2, 1'b1, 8'h11, 10);
    read_check("hold_spsr", 3'd1, 8'h01);
    bus_write(3'd2, 8'h22);
    bus_write(3'd2, 8'h33);
    bus_write(3'd2, 8'h44);
    read_check("txfull_spsr", 3'd1, 8'h09);
    bus_write(3'd2, 8'h55);
    read_check("wcol_spsr", 3'd1, 8'h49);
    bus_write(3'd1, 8'h40);
    read_check("wcol_clr_spsr", 3'd1, 8'h09);

    // Mode 1 back-to-back drain, then one more byte into a full RX.
    bus_write(3'd0, 8'h44);
    repeat (300) @(posedge Clk);
    read_check("m1_spsr", 3'd1, 8'h86);
    bus_write(3'd2, 8'h77);
    repeat (100) @(posedge Clk);
    read_check("rovr_spsr", 3'd1, 8'hA6);
    read_check("m1_rx0", 3'd2, 8'h11);
    read_check("m1_rx1", 3'd2, 8'h22);
    read_check("m1_rx2", 3'd2, 8'h33);
    read_check("m1_rx3", 3'd2, 8'h44);
    bus_write(3'd1, 8'hE0);
    read_check("flags_clr_spsr", 3'd1, 8'h05);

    // Mode 3, /32: abort after five SCLK edges.
    bus_write(3'd0, 8'h4F);
    clear_monitor();
    check("m3_sclk_idle", SCLK, 1'b1);
    bus_write(3'd2, 8'h5A);
    bus_write(3'd2, 8'h99);
    begin
      int n = 0;
      while (toggles < 5 && n < 2000) begin
        @(posedge Clk);
        n++;
      end
    end
    check("abort_edges_seen", toggles, 5);
    bus_write(3'd0, 8'h0F);
    check("abort_sclk", SCLK, 1'b1);
    repeat (100) @(posedge Clk);
    #1 check("abort_sclk_held", SCLK, 1'b1);
    check("abort_toggles", toggles, 6);
    read_check("abort_spsr", 3'd1, 8'h05);

    // Send 0x01 with SPER = 0x01; bit order depends on the build.
    bus_write(3'd3, 8'h01);
    bus_write(3'd0, 8'hC0);
    clear_monitor();
    bus_write(3'd2, 8'h01);
    wait_irq("lsb_irq", 200);
    check("lsb_rises", rises, 8);
    check("lsb_mosi_capture", cap, (sper_exp == 8'h01) ? 8'h80 : 8'h01);
    read_check("lsb_spdr", 3'd2, 8'h01);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
